rv32_pipe_ctrl: RTL

Pipeline sequencing controller for the RV32 core. It drives the stall, flush and busy controls of the IF/ID and ID/EX pipeline registers and holds the PC, based on hazards reported by decode and execute. It handles load-use interlock, redirect flush on taken branches and jumps, multi-cycle MDU waits with a watchdog, and halt/resume. It sits beside the decode stage and feeds the PC module, the IF/ID queue and the ID/EX queue directly.

---
 rtl/rv32_pipe_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rv32_pipe_ctrl.sv
// Pipeline sequencing controller: load-use interlock, redirect flush, MDU wait with watchdog, halt/resume.
// Optional perf counters built when RV32_PIPE_CTRL_PERF_EN is defined. Control outputs are combinational.
module rv32_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        perf_clr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_busy,
  output logic        mdu_timeout,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MDU_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t      cur_state, nxt_state;
  logic [2:0]  cnt, cnt_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        timeout_set;
  logic        load_use;
  logic        pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic        id_ex_stall_c, id_ex_flush_c, ex_busy_c;

  assign load_use = id_valid & ex_load & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= RUN;
      cnt         <= 3'd0;
      timer       <= 8'd0;
      mdu_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      if (timeout_set) mdu_timeout <= 1'b1;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    cnt_nxt       = cnt;
    timer_nxt     = timer;
    timeout_set   = 1'b0;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_stall_c = 1'b0;
    id_ex_flush_c = 1'b0;
    ex_busy_c     = 1'b0;
    case (cur_state)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nxt_state = REDIRECT;
            cnt_nxt   = 3'(FLUSH_CYCLES - 1);
          end
        end else if (ex_mdu_start) begin
          // A start with same-cycle done is a single-cycle op and masks lower priorities.
          if (!mdu_done) begin
            ex_busy_c     = 1'b1;
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            nxt_state     = MDU_WAIT;
            timer_nxt     = 8'd0;
          end
        end else if (load_use) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
        end else if (halt_req) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
          nxt_state     = HALT;
        end
      end
      REDIRECT: begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        if (cnt <= 3'd1) begin
          nxt_state = RUN;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          nxt_state = RUN;
          timer_nxt = 8'd0;
        end else if (timer == 8'(MDU_TIMEOUT - 1)) begin
          // Start cycle plus MDU_TIMEOUT-1 wait cycles have elapsed.
          timeout_set = 1'b1;
          nxt_state   = RUN;
          timer_nxt   = 8'd0;
        end else begin
          ex_busy_c     = 1'b1;
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          timer_nxt     = timer + 8'd1;
        end
      end
      HALT: begin
        if (resume) begin
          nxt_state = RUN;
        end else begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // Controls are forced low while reset is held, regardless of inputs.
  assign pc_stall    = rst_n & pc_stall_c;
  assign if_id_stall = rst_n & if_id_stall_c;
  assign if_id_flush = rst_n & if_id_flush_c;
  assign id_ex_stall = rst_n & id_ex_stall_c;
  assign id_ex_flush = rst_n & id_ex_flush_c;
  assign ex_busy     = rst_n & ex_busy_c;
  assign state       = cur_state;

`ifdef RV32_PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (perf_clr) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (id_ex_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr;
  assign stall_cnt       = 32'd0;
  assign flush_cnt       = 32'd0;
`endif

endmodule
